// File: rtl/round_scorekeeper.sv
// Match scorekeeper behind the light-field game: scores win-flag rises, holds, pulses round_reset.
// Optional 7-segment score display with winner blink is enabled by defining SCOREKEEPER_SEVSEG_EN.
module round_scorekeeper #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int CLEAR_CYCLES = 2,
  parameter int MAX_SCORE    = 7
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic       round_reset,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam int CMAX = (HOLD_CYCLES > CLEAR_CYCLES) ? HOLD_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [2:0]    MAX_S      = 3'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_p1, r_p2, w_p1_nxt, w_p2_nxt;
  logic [1:0]    r_winner, w_winner_nxt;
  logic          r_p1_prev, r_p2_prev, r_round_reset, r_game_over;
  logic          w_p1_rise, w_p2_rise;

  assign w_p1_rise = p1_win & ~r_p1_prev;
  assign w_p2_rise = p2_win & ~r_p2_prev;

`ifdef SCOREKEEPER_SEVSEG_EN
  logic       r_blank, w_blank_nxt;
  logic [6:0] r_hex0, r_hex1, w_hex0_nxt, w_hex1_nxt;

  function automatic logic [6:0] f_seg7(input logic [2:0] d);
    case (d)
      3'd0:    f_seg7 = 7'b1000000;
      3'd1:    f_seg7 = 7'b1111001;
      3'd2:    f_seg7 = 7'b0100100;
      3'd3:    f_seg7 = 7'b0110000;
      3'd4:    f_seg7 = 7'b0011001;
      3'd5:    f_seg7 = 7'b0010010;
      3'd6:    f_seg7 = 7'b0000010;
      3'd7:    f_seg7 = 7'b1111000;
      default: f_seg7 = 7'b1111111;
    endcase
  endfunction
`endif

  // Next-state, scoring and counter logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    w_winner_nxt = r_winner;
`ifdef SCOREKEEPER_SEVSEG_EN
    w_blank_nxt  = r_blank;
`endif
    case (r_state)
      ST_PLAY: begin
        w_cnt_nxt = '0;
        if (w_p1_rise & w_p2_rise) begin
          w_winner_nxt = 2'b00;
          w_state_nxt  = ST_HOLD;
        end else if (w_p1_rise) begin
          w_winner_nxt = 2'b01;
          w_p1_nxt     = (r_p1 == MAX_S) ? r_p1 : r_p1 + 3'd1;
          w_state_nxt  = ST_HOLD;
        end else if (w_p2_rise) begin
          w_winner_nxt = 2'b10;
          w_p2_nxt     = (r_p2 == MAX_S) ? r_p2 : r_p2 + 3'd1;
          w_state_nxt  = ST_HOLD;
        end else begin
          w_state_nxt  = ST_PLAY;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt = '0;
          if ((r_p1 == MAX_S) || (r_p2 == MAX_S)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_CLEAR;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_CLEAR: begin
        if (r_cnt == CLEAR_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PLAY;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
`ifdef SCOREKEEPER_SEVSEG_EN
        // Counter is reused as the blink period timer once the match is over
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_blank_nxt = ~r_blank;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`else
        w_cnt_nxt = r_cnt;
`endif
      end
      default: begin
        w_state_nxt = ST_PLAY;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef SCOREKEEPER_SEVSEG_EN
  // Display contents derived from next-cycle scores so HEX lines up with the score outputs
  always_comb begin
    w_hex0_nxt = f_seg7(w_p1_nxt);
    w_hex1_nxt = f_seg7(w_p2_nxt);
    if ((w_state_nxt == ST_DONE) && w_blank_nxt) begin
      if (w_winner_nxt == 2'b01) begin
        w_hex0_nxt = 7'b1111111;
      end else if (w_winner_nxt == 2'b10) begin
        w_hex1_nxt = 7'b1111111;
      end else begin
        w_hex0_nxt = f_seg7(w_p1_nxt);
      end
    end else begin
      w_hex1_nxt = f_seg7(w_p2_nxt);
    end
  end

  // Display registers
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_blank <= 1'b0;
      r_hex0  <= 7'b1000000;
      r_hex1  <= 7'b1000000;
    end else begin
      r_blank <= w_blank_nxt;
      r_hex0  <= w_hex0_nxt;
      r_hex1  <= w_hex1_nxt;
    end
  end

  assign HEX0 = r_hex0;
  assign HEX1 = r_hex1;
`else
  assign HEX0 = 7'b1111111;
  assign HEX1 = 7'b1111111;
`endif

  // State, score and registered control outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= ST_PLAY;
      r_cnt         <= '0;
      r_p1          <= 3'd0;
      r_p2          <= 3'd0;
      r_winner      <= 2'b00;
      r_p1_prev     <= 1'b0;
      r_p2_prev     <= 1'b0;
      r_round_reset <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_p1          <= w_p1_nxt;
      r_p2          <= w_p2_nxt;
      r_winner      <= w_winner_nxt;
      r_p1_prev     <= p1_win;
      r_p2_prev     <= p2_win;
      r_round_reset <= (w_state_nxt == ST_CLEAR);
      r_game_over   <= (w_state_nxt == ST_DONE);
    end
  end

  assign round_reset = r_round_reset;
  assign p1_score    = r_p1;
  assign p2_score    = r_p2;
  assign winner      = r_winner;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_round_scorekeeper.sv
// Self-checking bench for round_scorekeeper: directed scenarios followed by random play,
// compared each cycle against a round-timeline reference model.
module tb_round_scorekeeper;
  localparam int HOLD  = 4;
  localparam int CLR   = 2;
  localparam int MAXS  = 3;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       p1_win = 1'b0;
  logic       p2_win = 1'b0;
  logic       round_reset, game_over;
  logic [2:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [6:0] HEX0, HEX1;

  int checks = 0;
  int failures = 0;

  round_scorekeeper #(.HOLD_CYCLES(HOLD), .CLEAR_CYCLES(CLR), .MAX_SCORE(MAXS)) dut (
    .clk(clk), .Reset_n(Reset_n), .p1_win(p1_win), .p2_win(p2_win),
    .round_reset(round_reset), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .game_over(game_over), .HEX0(HEX0), .HEX1(HEX1)
  );

  always #5 clk = ~clk;

  // Reference model: a round is a timeline of HOLD cycles, then CLR cycles of restart
  int m_p1, m_p2, m_win, m_hold_left, m_clear_left, m_done_cycles;
  bit m_over, m_prev1, m_prev2;
  logic [6:0] seg_tab [8];

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_win = 0; m_over = 0;
    m_hold_left = 0; m_clear_left = 0; m_done_cycles = 0;
    m_prev1 = 0; m_prev2 = 0;
  endtask

  task automatic model_step(input bit a, input bit b);
    bit r1, r2;
    r1 = a && !m_prev1;
    r2 = b && !m_prev2;
    if (m_over) begin
      m_done_cycles++;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        if (m_p1 == MAXS || m_p2 == MAXS) m_over = 1;
        else m_clear_left = CLR;
      end
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (r1 || r2) begin
      if (r1 && r2) m_win = 0;
      else if (r1) begin m_win = 1; if (m_p1 < MAXS) m_p1++; end
      else begin m_win = 2; if (m_p2 < MAXS) m_p2++; end
      m_hold_left = HOLD;
    end
    m_prev1 = a;
    m_prev2 = b;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [6:0] e0, e1;
    bit blank;
    chk({tag, ":p1_score"}, {5'd0, p1_score}, 8'(m_p1));
    chk({tag, ":p2_score"}, {5'd0, p2_score}, 8'(m_p2));
    chk({tag, ":winner"}, {6'd0, winner}, 8'(m_win));
    chk({tag, ":game_over"}, {7'd0, game_over}, 8'(m_over));
    chk({tag, ":round_reset"}, {7'd0, round_reset}, 8'(m_clear_left > 0));
`ifdef SCOREKEEPER_SEVSEG_EN
    e0 = seg_tab[m_p1];
    e1 = seg_tab[m_p2];
    blank = m_over && (((m_done_cycles / HOLD) % 2) == 1);
    if (blank && m_win == 1) e0 = 7'b1111111;
    if (blank && m_win == 2) e1 = 7'b1111111;
`else
    e0 = 7'b1111111;
    e1 = 7'b1111111;
    blank = 1'b0;
`endif
    chk({tag, ":HEX0"}, {1'b0, HEX0}, {1'b0, e0});
    chk({tag, ":HEX1"}, {1'b0, HEX1}, {1'b0, e1});
  endtask

  task automatic tick(input bit a, input bit b, input string tag);
    p1_win = a;
    p2_win = b;
    @(posedge clk);
    model_step(a, b);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    model_reset();
    @(negedge clk);
    check_all("reset");
    Reset_n = 1'b1;

    // 1: held p1 level scores once, hold, restart pulse, no re-score
    tick(1'b1, 1'b0, "t1_rise");
    chk("t1_p1_is_1", {5'd0, p1_score}, 8'd1);
    for (int i = 0; i < HOLD; i++) tick(1'b1, 1'b0, "t1_hold");
    chk("t1_rr_high", {7'd0, round_reset}, 8'd1);
    for (int i = 0; i < CLR + 3; i++) tick(1'b1, 1'b0, "t1_after");
    chk("t1_no_rescore", {5'd0, p1_score}, 8'd1);

    // 2: simultaneous rise is a tie round
    tick(1'b0, 1'b0, "t2_low");
    tick(1'b1, 1'b1, "t2_tie");
    chk("t2_winner_00", {6'd0, winner}, 8'd0);
    for (int i = 0; i < HOLD + CLR; i++) tick(1'b0, 1'b0, "t2_wait");

    // 5: p2 pulse during HOLD is ignored
    tick(1'b0, 1'b1, "t5_score");
    tick(1'b0, 1'b0, "t5_h1");
    tick(1'b0, 1'b1, "t5_pulse");
    tick(1'b0, 1'b0, "t5_h3");
    chk("t5_p2_is_1", {5'd0, p2_score}, 8'd1);
    for (int i = 0; i < CLR + 1; i++) tick(1'b0, 1'b0, "t5_wait");

    // 4: reset during first CLEAR cycle
    tick(1'b1, 1'b0, "t4_score");
    for (int i = 0; i < HOLD; i++) tick(1'b0, 1'b0, "t4_hold");
    do_reset("t4_rst");
    chk("t4_rr_low", {7'd0, round_reset}, 8'd0);

    // 3: p2 takes the match, then everything is frozen
    for (int r = 0; r < MAXS; r++) begin
      tick(1'b0, 1'b1, "t3_score");
      for (int i = 0; i < HOLD + CLR; i++) tick(1'b0, 1'b0, "t3_wait");
    end
    chk("t3_game_over", {7'd0, game_over}, 8'd1);
    chk("t3_winner_10", {6'd0, winner}, 8'd2);
    for (int i = 0; i < 12; i++) tick(i[0], i[1], "t3_frozen");
    chk("t3_p2_is_3", {5'd0, p2_score}, 8'd3);

    // random play with occasional asynchronous reset
    do_reset("rnd_rst0");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
